// File: rtl/median_filter_pkg.sv
// -----------------------------------------------------------------------------
// median_filter_pkg
// Shared definitions for the binary median filter and its pass scheduler:
//   - pass_state_t : scheduler state encoding
//   - ACTIVE_W     : width of the filter's active-window count
//   - PASS_W       : width of the completed-pass counter (holds 0..8)
//   - NUMPASS_W    : width of the requested-passes-minus-one field
//   - ADDR_W       : frame address width, shared with the filter
// -----------------------------------------------------------------------------
package median_filter_pkg;

    localparam int ACTIVE_W  = 13;
    localparam int PASS_W    = 4;
    localparam int NUMPASS_W = 3;
    localparam int ADDR_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        KICK,
        RUN,
        EVAL,
        DONE
    } pass_state_t;

endpackage

// File: rtl/median_pass_scheduler_pass_watchdog.sv
// -----------------------------------------------------------------------------
// pass_watchdog
// Cycle counter with synchronous clear and count enable. limitHit is high
// during the LIMIT-th consecutive enabled cycle after a clear, so the owner
// can leave its waiting state on the following edge.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-low reset
//   clear    in  restart the count from zero
//   enable   in  count this cycle
//   limitHit out LIMIT enabled cycles have elapsed (combinational)
// -----------------------------------------------------------------------------
module pass_watchdog #(
    parameter int LIMIT = 400000,
    parameter int W     = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic limitHit
);

    logic [W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !limitHit) begin
            count <= count + W'(1);
        end
    end

    assign limitHit = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/median_pass_scheduler.sv
// -----------------------------------------------------------------------------
// median_pass_scheduler
// Sequences the median filteringModule over 1..8 passes of a frame,
// ping-ponging source/destination banks between passes and stopping early
// once the active-window count stops changing.
//
// Optional feature: define MEDIAN_PASS_WATCHDOG_EN to build a watchdog that
// aborts a job stuck in ARM or RUN for WDOG_LIMIT cycles (errTimeout=1,
// resultBank = last complete image). Without it, errTimeout stays 0 and ARM
// and RUN wait indefinitely.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   hostStart           job request, sampled in IDLE only
//   numPasses           requested passes minus one, latched at job accept
//   hostBusy            job in progress (ARM through DONE)
//   hostDone            one-cycle completion pulse
//   passCount           completed passes of the current/last job
//   resultBank          bank holding the final image, valid with hostDone
//   converged           last job stopped early on equal counts
//   errTimeout          sticky watchdog flag, cleared on job accept
//   filterStart         one-cycle start pulse to the filter
//   filterReady         filter idle and able to accept a start
//   filterDone          filter pass-complete pulse
//   activeWindows       filter window count, valid with filterDone
//   srcBank / dstBank   banks the filter reads / writes (dstBank = ~srcBank)
//   lastActiveWindows   count captured at the most recent filterDone
// -----------------------------------------------------------------------------
module median_pass_scheduler
    import median_filter_pkg::*;
#(
    parameter int WDOG_LIMIT = 400000,
    parameter int WDOG_W     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hostStart,
    input  logic [NUMPASS_W-1:0] numPasses,
    output logic                 hostBusy,
    output logic                 hostDone,
    output logic [PASS_W-1:0]    passCount,
    output logic                 resultBank,
    output logic                 converged,
    output logic                 errTimeout,
    output logic                 filterStart,
    input  logic                 filterReady,
    input  logic                 filterDone,
    input  logic [ACTIVE_W-1:0]  activeWindows,
    output logic                 srcBank,
    output logic                 dstBank,
    output logic [ACTIVE_W-1:0]  lastActiveWindows
);

    if (longint'(WDOG_LIMIT) >= (longint'(1) << WDOG_W)) begin : gWdogCfgBad
        $error("WDOG_LIMIT must be below 2**WDOG_W");
    end

    pass_state_t          state;
    logic [NUMPASS_W-1:0] numPassesLat;
    logic [ACTIVE_W-1:0]  prevActive;
    logic                 wdogHit;

`ifdef MEDIAN_PASS_WATCHDOG_EN
    logic wdogWaiting;

    // Counting only in ARM/RUN and clearing everywhere else restarts the
    // count on every entry to either state.
    assign wdogWaiting = (state == ARM) || (state == RUN);

    pass_watchdog #(
        .LIMIT (WDOG_LIMIT),
        .W     (WDOG_W)
    ) uWatchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (!wdogWaiting),
        .enable   (wdogWaiting),
        .limitHit (wdogHit)
    );
`else
    assign wdogHit = 1'b0;
`endif

    // The destination is always the other bank, so it is never stored.
    assign dstBank = ~srcBank;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            hostBusy          <= 1'b0;
            hostDone          <= 1'b0;
            filterStart       <= 1'b0;
            converged         <= 1'b0;
            errTimeout        <= 1'b0;
            passCount         <= '0;
            lastActiveWindows <= '0;
            prevActive        <= '0;
            resultBank        <= 1'b0;
            srcBank           <= 1'b0;
            numPassesLat      <= '0;
        end else begin
            // Pulses default low and are raised only on the edge entering
            // their state, which keeps them exactly one cycle wide.
            hostDone    <= 1'b0;
            filterStart <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (hostStart) begin
                        numPassesLat <= numPasses;
                        passCount    <= '0;
                        converged    <= 1'b0;
                        errTimeout   <= 1'b0;
                        srcBank      <= 1'b0;
                        hostBusy     <= 1'b1;
                        state        <= ARM;
                    end
                end

                ARM: begin
                    if (filterReady) begin
                        filterStart <= 1'b1;
                        state       <= KICK;
                    end else if (wdogHit) begin
                        // Abort: srcBank still holds the last complete image.
                        errTimeout <= 1'b1;
                        hostDone   <= 1'b1;
                        resultBank <= srcBank;
                        state      <= DONE;
                    end
                end

                // filterDone is deliberately not looked at here, so RUN
                // always waits for a pulse that follows the start.
                KICK: state <= RUN;

                RUN: begin
                    if (filterDone) begin
                        prevActive        <= lastActiveWindows;
                        lastActiveWindows <= activeWindows;
                        passCount         <= passCount + PASS_W'(1);
                        state             <= EVAL;
                    end else if (wdogHit) begin
                        errTimeout <= 1'b1;
                        hostDone   <= 1'b1;
                        resultBank <= srcBank;
                        state      <= DONE;
                    end
                end

                EVAL: begin
                    // The pass-limit test takes priority, so equal counts on
                    // the final pass do not report convergence. The passCount
                    // guard keeps pass 1 from comparing against a stale count
                    // left over from the previous job.
                    if (passCount == PASS_W'(numPassesLat) + PASS_W'(1)) begin
                        hostDone   <= 1'b1;
                        resultBank <= ~srcBank;
                        state      <= DONE;
                    end else if (passCount >= PASS_W'(2) &&
                                 lastActiveWindows == prevActive) begin
                        converged  <= 1'b1;
                        hostDone   <= 1'b1;
                        resultBank <= ~srcBank;
                        state      <= DONE;
                    end else begin
                        // The image just written becomes the next source.
                        srcBank <= ~srcBank;
                        state   <= ARM;
                    end
                end

                DONE: begin
                    hostBusy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_pass_scheduler.sv
// -----------------------------------------------------------------------------
// tb_median_pass_scheduler
// Self-checking bench for median_pass_scheduler. Stimulus pushes the expected
// job outcome (computed from the pass/convergence rules) into a queue; a
// monitor pops and compares whenever hostDone is seen, and also checks bank
// order and handshake latencies at every filterStart. A behavioural filter
// answers each filterStart with a filterDone pulse after a chosen delay.
// -----------------------------------------------------------------------------
module tb_median_pass_scheduler;

    localparam int WDOG_LIMIT_TB = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hostStart = 1'b0;
    logic [2:0]  numPasses = 3'd0;
    logic        hostBusy, hostDone, resultBank, converged, errTimeout;
    logic [3:0]  passCount;
    logic        filterStart;
    logic        filterReady = 1'b1;
    logic        filterDone;
    logic [12:0] activeWindows;
    logic        srcBank, dstBank;
    logic [12:0] lastActiveWindows;

    // Filter-side drivers: the behavioural filter and directed spurious pulses.
    logic        modelDone = 1'b0;
    logic [12:0] modelAw = 13'd0;
    logic        spuriousDone = 1'b0;
    logic [12:0] spuriousAw = 13'd0;

    assign filterDone    = modelDone | spuriousDone;
    assign activeWindows = modelDone ? modelAw : spuriousAw;

    always #5 clk = ~clk;

    median_pass_scheduler #(
        .WDOG_LIMIT (WDOG_LIMIT_TB),
        .WDOG_W     (20)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .hostStart         (hostStart),
        .numPasses         (numPasses),
        .hostBusy          (hostBusy),
        .hostDone          (hostDone),
        .passCount         (passCount),
        .resultBank        (resultBank),
        .converged         (converged),
        .errTimeout        (errTimeout),
        .filterStart       (filterStart),
        .filterReady       (filterReady),
        .filterDone        (filterDone),
        .activeWindows     (activeWindows),
        .srcBank           (srcBank),
        .dstBank           (dstBank),
        .lastActiveWindows (lastActiveWindows)
    );

    typedef struct {
        int passes;
        bit conv;
        bit bank;
        bit tmo;
        int law;
    } exp_t;

    exp_t expQ[$];
    int   cntQ[$];

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int doneCount = 0;
    int kickIdx = 0;
    int epoch = 0;
    int doneDelay = 5;
    bit autoFilter = 1'b1;
    bit kickLatCheck = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Outcome of a job from the pass rules: stop after numPasses+1 passes, or
    // earlier once two consecutive passes of this job report the same count.
    // Pass k (1-based) writes bank k mod 2.
    function automatic exp_t refModel(input int n, input int cnt[8]);
        exp_t e;
        e.tmo    = 1'b0;
        e.conv   = 1'b0;
        e.passes = 0;
        for (int i = 0; i <= n; i++) begin
            e.passes = i + 1;
            if (e.passes == n + 1) break;
            if (i > 0 && cnt[i] == cnt[i-1]) begin
                e.conv = 1'b1;
                break;
            end
        end
        e.law  = cnt[e.passes-1];
        e.bank = (e.passes % 2) == 1;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural filter.
    initial forever begin
        int ep, v, d;
        @(negedge clk);
        if (filterStart && reset && autoFilter) begin
            ep = epoch;
            d  = doneDelay;
            v  = (cntQ.size() > 0) ? cntQ.pop_front() : 0;
            for (int k = 0; k < d && ep == epoch; k++) @(posedge clk);
            #1;
            if (ep == epoch) begin
                modelAw   = 13'(v);
                modelDone = 1'b1;
                @(posedge clk);
                #1 modelDone = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        int acceptCyc, lastDoneCyc, lastKickCyc;
        bit doneSeen;
        acceptCyc = 0; lastDoneCyc = 0; lastKickCyc = 0; doneSeen = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                kickIdx  = 0;
                doneSeen = 1'b0;
                continue;
            end
            if (hostStart && !hostBusy) begin
                acceptCyc = cyc;
                kickIdx   = 0;
                doneSeen  = 1'b0;
            end
            if (modelDone) begin
                lastDoneCyc = cyc;
                doneSeen    = 1'b1;
            end
            if (filterStart) begin
                kickIdx++;
                check("kick srcBank", srcBank, (kickIdx - 1) % 2);
                check("kick dstBank", dstBank, !srcBank);
                if (doneSeen)
                    check("filterDone->filterStart latency", cyc - lastDoneCyc, 3);
                else if (kickLatCheck)
                    check("hostStart->filterStart latency", cyc - acceptCyc, 2);
                lastKickCyc = cyc;
            end
            if (hostDone) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    check("unexpected hostDone", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("passCount", passCount, e.passes);
                    check("resultBank", resultBank, e.bank);
                    check("converged", converged, e.conv);
                    check("errTimeout", errTimeout, e.tmo);
                    check("lastActiveWindows", lastActiveWindows, e.law);
                    check("hostBusy in DONE", hostBusy, 1);
                    check("filterStart count", kickIdx, e.tmo ? 1 : e.passes);
                    if (e.tmo)
                        check("watchdog latency", cyc - lastKickCyc, WDOG_LIMIT_TB + 1);
                    else
                        check("filterDone->hostDone latency", cyc - lastDoneCyc, 2);
                end
            end
        end
    end

    task automatic startJob(input int n, input int cnt[8], input int d);
        exp_t e;
        e = refModel(n, cnt);
        for (int i = 0; i < e.passes; i++) cntQ.push_back(cnt[i]);
        expQ.push_back(e);
        doneDelay = d;
        @(posedge clk);
        #1 numPasses = 3'(n);
        hostStart = 1'b1;
        @(posedge clk);
        #1 hostStart = 1'b0;
        numPasses = 3'($urandom);   // must not affect the latched value
    endtask

    task automatic waitDone(input int target, input int budget);
        int k;
        k = 0;
        while (doneCount < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (doneCount < target) check("hostDone wait expired", doneCount, target);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 epoch++;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        expQ.delete();
        cntQ.delete();
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " hostBusy"}, hostBusy, 0);
        check({tag, " hostDone"}, hostDone, 0);
        check({tag, " filterStart"}, filterStart, 0);
        check({tag, " converged"}, converged, 0);
        check({tag, " errTimeout"}, errTimeout, 0);
        check({tag, " passCount"}, passCount, 0);
        check({tag, " lastActiveWindows"}, lastActiveWindows, 0);
        check({tag, " resultBank"}, resultBank, 0);
        check({tag, " srcBank"}, srcBank, 0);
        check({tag, " dstBank"}, dstBank, 1);
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL global time limit: got running, required finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        int want, k, n, d;
        int c[8];
        want = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkResetValues("reset");

        // Single pass.
        startJob(0, '{500, 0, 0, 0, 0, 0, 0, 0}, 100);
        want++; waitDone(want, 400);

        // Three passes, bank order 0,1,0.
        startJob(2, '{900, 700, 650, 0, 0, 0, 0, 0}, 20);
        want++; waitDone(want, 500);

        // Early convergence after pass 3 of 8.
        startJob(7, '{800, 640, 640, 1, 2, 3, 4, 5}, 15);
        want++; waitDone(want, 500);

        // Handshake stall with spurious filterDone in ARM and in KICK.
        filterReady  = 1'b0;
        kickLatCheck = 1'b0;
        startJob(1, '{300, 301, 0, 0, 0, 0, 0, 0}, 10);
        repeat (10) @(posedge clk);
        #1 spuriousAw = 13'd4444;
        spuriousDone = 1'b1;
        @(posedge clk);
        #1 spuriousDone = 1'b0;
        repeat (40) @(posedge clk);
        check("stall filterStart count", kickIdx, 0);
        check("stall passCount", passCount, 0);
        #1 filterReady = 1'b1;
        @(negedge clk);
        check("filterStart same cycle as ready", filterStart, 0);
        @(negedge clk);
        check("filterStart cycle after ready", filterStart, 1);
        spuriousDone = 1'b1;
        @(posedge clk);
        #1 spuriousDone = 1'b0;
        kickLatCheck = 1'b1;
        want++; waitDone(want, 300);

        // 13-bit boundaries: MSB-only difference, equal counts on the final
        // pass (no convergence), earliest convergence at pass 2, and a first
        // pass matching the previous job's count.
        startJob(3, '{5, 4101, 5, 5, 0, 0, 0, 0}, 4);
        want++; waitDone(want, 300);
        startJob(4, '{8191, 8191, 0, 0, 0, 0, 0, 0}, 3);
        want++; waitDone(want, 300);
        startJob(1, '{8191, 100, 0, 0, 0, 0, 0, 0}, 3);
        want++; waitDone(want, 300);

        // hostStart held through DONE -> IDLE starts a second job at once.
        begin
            exp_t ea, eb;
            ea = refModel(1, '{120, 130, 0, 0, 0, 0, 0, 0});
            eb = refModel(1, '{140, 140, 0, 0, 0, 0, 0, 0});
            cntQ.push_back(120); cntQ.push_back(130);
            cntQ.push_back(140); cntQ.push_back(140);
            expQ.push_back(ea); expQ.push_back(eb);
            doneDelay = 8;
            @(posedge clk);
            #1 numPasses = 3'd1;
            hostStart = 1'b1;
            want++; waitDone(want, 300);
            @(posedge clk);
            #1 hostStart = 1'b0;
            want++; waitDone(want, 300);
        end

        // Randomised jobs; counts drawn from a narrow set so that
        // convergence is frequent, mixed with full-range values.
        for (int j = 0; j < 10; j++) begin
            n = $urandom_range(0, 7);
            d = $urandom_range(1, 12);
            for (int i = 0; i < 8; i++)
                c[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8191))
                                                   : 600 + int'($urandom_range(0, 1));
            startJob(n, c, d);
            want++; waitDone(want, 2000);
        end

`ifdef MEDIAN_PASS_WATCHDOG_EN
        // Filter never answers: abort after WDOG_LIMIT RUN cycles.
        pulseReset();
        autoFilter = 1'b0;
        begin
            exp_t et;
            et.passes = 0; et.conv = 1'b0; et.bank = 1'b0; et.tmo = 1'b1; et.law = 0;
            expQ.push_back(et);
        end
        @(posedge clk);
        #1 numPasses = 3'd7;
        hostStart = 1'b1;
        @(posedge clk);
        #1 hostStart = 1'b0;
        want++; waitDone(want, 300);
        check("timeout srcBank", srcBank, 0);
        autoFilter = 1'b1;
        // errTimeout must clear on the next accept.
        startJob(0, '{77, 0, 0, 0, 0, 0, 0, 0}, 5);
        want++; waitDone(want, 300);
`else
        // Without the watchdog the block waits in RUN indefinitely.
        autoFilter = 1'b0;
        @(posedge clk);
        #1 numPasses = 3'd0;
        hostStart = 1'b1;
        @(posedge clk);
        #1 hostStart = 1'b0;
        repeat (200) @(posedge clk);
        check("no watchdog hostBusy", hostBusy, 1);
        check("no watchdog hostDone count", doneCount, want);
        check("no watchdog filterStart count", kickIdx, 1);
        check("no watchdog errTimeout", errTimeout, 0);
        pulseReset();
        autoFilter = 1'b1;
`endif

        // Mid-job reset during pass 2, then a clean job from bank 0.
        startJob(3, '{1000, 900, 800, 700, 0, 0, 0, 0}, 30);
        k = 0;
        while (kickIdx < 2 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("reached pass 2", kickIdx, 2);
        repeat (5) @(posedge clk);
        pulseReset();
        @(negedge clk);
        checkResetValues("mid-job reset");
        startJob(2, '{10, 20, 30, 0, 0, 0, 0, 0}, 6);
        want++; waitDone(want, 300);

        repeat (5) @(posedge clk);
        check("total hostDone count", doneCount, want);
        check("scoreboard drained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
